mul_unit: RTL

- Multi-cycle shift-add multiplier that sits directly upstream of the 16-bit result register in the PICO16a datapath.
- Accepts two operands on a start pulse and iterates one bit per cycle.
- When finished, drives the low product word onto the register data input with a one-cycle write-enable pulse.
- Also exposes the high product word for a second destination register.

---
 rtl/mul_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - multi-cycle shift-add multiplier feeding the 16-bit result register
module mul_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_hi,
  output logic             wr_en,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [WIDTH-1:0]   dout_hi_q, dout_hi_d;
  logic               wr_en_q, wr_en_d;
  logic               busy_q, busy_d;

  // Signed operands are reduced to magnitudes; 0x8000 maps onto itself as unsigned.
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] result;

  assign mag_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (sgn && b[WIDTH-1]) ? -b : b;
  assign result = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      dout_q    <= '0;
      dout_hi_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      dout_q    <= dout_d;
      dout_hi_q <= dout_hi_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    dout_d    = dout_q;
    dout_hi_d = dout_hi_q;
    wr_en_d   = 1'b0;
    busy_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          cnt_d    = '0;
          neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      FIX: begin
        dout_d    = result[WIDTH-1:0];
        dout_hi_d = result[2*WIDTH-1:WIDTH];
        wr_en_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign dout    = dout_q;
  assign dout_hi = dout_hi_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;

endmodule
